// File: rtl/cms_trace_gate_pkg.sv
// Shared types and constants for the instruction-trace gate: FSM states,
// control-address function codes and the WFI encoding.
package cms_trace_gate_pkg;

  typedef enum logic [1:0] {
    ARMED   = 2'd0,
    TRACING = 2'd1,
    HALTED  = 2'd2
  } gate_state_e;

  // Upper nibble of ctrl_addr selects the function, lower nibble the index.
  localparam logic [3:0] FN_RANGE_LO   = 4'h0;
  localparam logic [3:0] FN_RANGE_HI   = 4'h1;
  localparam logic [3:0] FN_RANGE_CFG  = 4'h2;
  localparam logic [3:0] FN_TRIG_START = 4'h3;
  localparam logic [3:0] FN_TRIG_END   = 4'h4;
  localparam logic [3:0] FN_TRIG_EN    = 4'h5;
  localparam logic [3:0] FN_CMD        = 4'h6;

  localparam logic [3:0] CMD_REARM       = 4'h0;
  localparam logic [3:0] CMD_CLEAR_DROPS = 4'h1;

  localparam logic [31:0] WFI_INSTRUCTION = 32'h1050_0073;

endpackage

// File: rtl/cms_trace_gate_if.sv
// Trace packet stream between the gate and its sink (valid/ready handshake).
interface cms_trace_gate_if #(
  parameter int XLEN        = 64,
  parameter int INSTR_WIDTH = 32,
  parameter int DELTA_WIDTH = 32
);
  logic                   out_valid;
  logic                   out_ready;
  logic [XLEN-1:0]        out_pc;
  logic [INSTR_WIDTH-1:0] out_instr;
  logic [DELTA_WIDTH-1:0] out_delta;
  logic                   out_ovf;
  logic                   out_last;

  modport master (
    output out_valid, out_pc, out_instr, out_delta, out_ovf, out_last,
    input  out_ready
  );

  modport slave (
    input  out_valid, out_pc, out_instr, out_delta, out_ovf, out_last,
    output out_ready
  );
endinterface

// File: rtl/cms_sync_fifo.sv
// Single-clock FIFO with registered storage; accepts a push while full when
// a pop happens in the same cycle. Storage is cleared on reset.
module cms_sync_fifo #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             push,
  input  logic [WIDTH-1:0] push_data,
  input  logic             pop,
  output logic [WIDTH-1:0] pop_data,
  output logic             full,
  output logic             empty
);
  localparam int AW = $clog2(DEPTH);

  logic [WIDTH-1:0] mem_r [DEPTH];
  logic [AW-1:0]    wr_ptr_r;
  logic [AW-1:0]    rd_ptr_r;
  logic [AW:0]      count_r;
  logic             push_ok_s;
  logic             pop_ok_s;

  // Qualify the requests against the occupancy flags.
  always_comb begin
    pop_ok_s  = pop && !empty;
    push_ok_s = push && (!full || pop_ok_s);
  end

  // Storage, pointers and occupancy count.
  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr_r <= '0;
      rd_ptr_r <= '0;
      count_r  <= '0;
      for (int i = 0; i < DEPTH; i++) begin
        mem_r[i] <= '0;
      end
    end else begin
      if (push_ok_s) begin
        mem_r[wr_ptr_r] <= push_data;
        wr_ptr_r        <= wr_ptr_r + AW'(1);
      end else begin
        wr_ptr_r <= wr_ptr_r;
      end
      if (pop_ok_s) begin
        rd_ptr_r <= rd_ptr_r + AW'(1);
      end else begin
        rd_ptr_r <= rd_ptr_r;
      end
      case ({push_ok_s, pop_ok_s})
        2'b10:   count_r <= count_r + (AW+1)'(1);
        2'b01:   count_r <= count_r - (AW+1)'(1);
        default: count_r <= count_r;
      endcase
    end
  end

  assign full     = (count_r == (AW+1)'(DEPTH));
  assign empty    = (count_r == (AW+1)'(0));
  assign pop_data = mem_r[rd_ptr_r];

endmodule

// File: rtl/cms_trace_gate.sv
// Instruction-trace gate: start/end triggered trace window, address-range
// filtering, timestamp deltas and a buffered packet stream with drop tracking.
module cms_trace_gate
  import cms_trace_gate_pkg::*;
#(
  parameter int XLEN         = 64,
  parameter int INSTR_WIDTH  = 32,
  parameter int NUM_RANGES   = 4,
  parameter int NUM_TRIGGERS = 2,
  parameter int FIFO_DEPTH   = 8,
  parameter int DELTA_WIDTH  = 32,
  parameter int DROP_WIDTH   = 16
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic [XLEN-1:0]        pc,
  input  logic [INSTR_WIDTH-1:0] instr,
  input  logic                   pc_valid,
  input  logic                   en,
  input  logic [7:0]             ctrl_addr,
  input  logic [XLEN-1:0]        ctrl_wdata,
  input  logic                   ctrl_we,
  cms_trace_gate_if.master       pkt,
  output logic [DROP_WIDTH-1:0]  dropped_count,
  output logic [1:0]             gate_state
);
  localparam int PKT_W = XLEN + INSTR_WIDTH + DELTA_WIDTH + 2;

  // S1 copy of the retire port
  logic                   s1_valid_r;
  logic [XLEN-1:0]        s1_pc_r;
  logic [INSTR_WIDTH-1:0] s1_instr_r;

  // Filter and trigger configuration
  logic [XLEN-1:0]         lo_r       [NUM_RANGES];
  logic [XLEN-1:0]         hi_r       [NUM_RANGES];
  logic [NUM_RANGES-1:0]   rng_en_r;
  logic [NUM_RANGES-1:0]   rng_excl_r;
  logic [XLEN-1:0]         start_r    [NUM_TRIGGERS];
  logic [XLEN-1:0]         end_r      [NUM_TRIGGERS];
  logic [NUM_TRIGGERS-1:0] start_en_r;
  logic [NUM_TRIGGERS-1:0] end_en_r;

  gate_state_e state_r;
  gate_state_e state_nxt_s;

  logic [DELTA_WIDTH-1:0] since_r;
  logic                   first_r;
  logic [DROP_WIDTH-1:0]  dropped_count_r;
  logic                   ovf_pend_r;

  logic [3:0]             ctrl_fn_s;
  logic [3:0]             ctrl_idx_s;
  logic                   rearm_s;
  logic                   clr_drops_s;
  logic                   incl_any_s;
  logic                   incl_hit_s;
  logic                   excl_hit_s;
  logic                   range_pass_s;
  logic                   start_any_s;
  logic                   start_hit_s;
  logic                   end_hit_s;
  logic                   trig_start_s;
  logic                   trig_end_s;
  logic                   eligible_s;
  logic                   last_s;
  logic                   accept_s;
  logic                   pop_s;
  logic                   drop_s;
  logic                   push_s;
  logic [DELTA_WIDTH-1:0] delta_s;
  logic [PKT_W-1:0]       push_data_s;
  logic [PKT_W-1:0]       pop_data_s;
  logic                   fifo_full_s;
  logic                   fifo_empty_s;

  // S1 pipeline register: every decision below is made on these values.
  always_ff @(posedge clk) begin
    if (rst) begin
      s1_valid_r <= 1'b0;
      s1_pc_r    <= '0;
      s1_instr_r <= '0;
    end else begin
      s1_valid_r <= pc_valid;
      s1_pc_r    <= pc;
      s1_instr_r <= instr;
    end
  end

  // Control address decode for the command-style writes.
  always_comb begin
    ctrl_fn_s   = ctrl_addr[7:4];
    ctrl_idx_s  = ctrl_addr[3:0];
    rearm_s     = ctrl_we && (ctrl_addr == {FN_CMD, CMD_REARM});
    clr_drops_s = ctrl_we && (ctrl_addr == {FN_CMD, CMD_CLEAR_DROPS});
  end

  // Configuration registers; indices beyond the instantiated count never match.
  always_ff @(posedge clk) begin
    if (rst) begin
      rng_en_r   <= '0;
      rng_excl_r <= '0;
      start_en_r <= '0;
      end_en_r   <= '0;
      for (int i = 0; i < NUM_RANGES; i++) begin
        lo_r[i] <= '0;
        hi_r[i] <= '1;
      end
      for (int j = 0; j < NUM_TRIGGERS; j++) begin
        start_r[j] <= '0;
        end_r[j]   <= '0;
      end
    end else if (ctrl_we) begin
      for (int i = 0; i < NUM_RANGES; i++) begin
        if (ctrl_idx_s == 4'(i)) begin
          case (ctrl_fn_s)
            FN_RANGE_LO:  lo_r[i] <= ctrl_wdata;
            FN_RANGE_HI:  hi_r[i] <= ctrl_wdata;
            FN_RANGE_CFG: begin
              rng_en_r[i]   <= ctrl_wdata[0];
              rng_excl_r[i] <= ctrl_wdata[1];
            end
            default: lo_r[i] <= lo_r[i];
          endcase
        end
      end
      for (int j = 0; j < NUM_TRIGGERS; j++) begin
        if (ctrl_idx_s == 4'(j)) begin
          case (ctrl_fn_s)
            FN_TRIG_START: start_r[j] <= ctrl_wdata;
            FN_TRIG_END:   end_r[j]   <= ctrl_wdata;
            default:       start_r[j] <= start_r[j];
          endcase
        end
      end
      if (ctrl_addr == {FN_TRIG_EN, 4'h0}) begin
        start_en_r <= ctrl_wdata[NUM_TRIGGERS-1:0];
        end_en_r   <= ctrl_wdata[2*NUM_TRIGGERS-1:NUM_TRIGGERS];
      end else begin
        start_en_r <= start_en_r;
      end
    end else begin
      rng_en_r <= rng_en_r;
    end
  end

  // Range filter and trigger comparators on the S1 PC.
  always_comb begin
    incl_any_s  = 1'b0;
    incl_hit_s  = 1'b0;
    excl_hit_s  = 1'b0;
    start_any_s = |start_en_r;
    start_hit_s = 1'b0;
    end_hit_s   = 1'b0;
    for (int i = 0; i < NUM_RANGES; i++) begin
      incl_any_s = incl_any_s | (rng_en_r[i] & ~rng_excl_r[i]);
      incl_hit_s = incl_hit_s | (rng_en_r[i] & ~rng_excl_r[i] &
                                 (s1_pc_r >= lo_r[i]) & (s1_pc_r <= hi_r[i]));
      excl_hit_s = excl_hit_s | (rng_en_r[i] & rng_excl_r[i] &
                                 (s1_pc_r >= lo_r[i]) & (s1_pc_r <= hi_r[i]));
    end
    for (int j = 0; j < NUM_TRIGGERS; j++) begin
      start_hit_s = start_hit_s | (start_en_r[j] & (s1_pc_r == start_r[j]));
      end_hit_s   = end_hit_s   | (end_en_r[j]   & (s1_pc_r == end_r[j]));
    end
    range_pass_s = (!incl_any_s || incl_hit_s) && !excl_hit_s;
    trig_start_s = s1_valid_r && start_hit_s;
    trig_end_s   = s1_valid_r &&
                   (end_hit_s || (s1_instr_r == INSTR_WIDTH'(WFI_INSTRUCTION)));
  end

  // FSM state register.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_r <= ARMED;
    end else begin
      state_r <= state_nxt_s;
    end
  end

  // FSM next state; ARMED without any start trigger tracks like TRACING.
  always_comb begin
    state_nxt_s = state_r;
    if (rearm_s) begin
      state_nxt_s = ARMED;
    end else begin
      case (state_r)
        ARMED: begin
          if (start_any_s) begin
            state_nxt_s = trig_start_s ? TRACING : ARMED;
          end else begin
            state_nxt_s = trig_end_s ? HALTED : ARMED;
          end
        end
        TRACING: state_nxt_s = trig_end_s ? HALTED : TRACING;
        HALTED:  state_nxt_s = HALTED;
        default: state_nxt_s = ARMED;
      endcase
    end
  end

  // FSM outputs: eligibility of the S1 sample and its end-of-window mark.
  always_comb begin
    eligible_s = 1'b0;
    last_s     = 1'b0;
    case (state_r)
      ARMED: begin
        if (start_any_s) begin
          eligible_s = trig_start_s;
          last_s     = 1'b0;
        end else begin
          eligible_s = 1'b1;
          last_s     = trig_end_s;
        end
      end
      TRACING: begin
        eligible_s = 1'b1;
        last_s     = trig_end_s;
      end
      HALTED:  eligible_s = 1'b0;
      default: eligible_s = 1'b0;
    endcase
  end

  // Acceptance, drop and push decisions for the S1 sample.
  always_comb begin
    accept_s    = s1_valid_r && en && eligible_s && range_pass_s;
    pop_s       = !fifo_empty_s && pkt.out_ready;
    drop_s      = accept_s && fifo_full_s && !pop_s;
    push_s      = accept_s && !drop_s;
    delta_s     = first_r ? '0 : since_r;
    push_data_s = {s1_pc_r, s1_instr_r, delta_s, ovf_pend_r, last_s};
  end

  // Delta reference: dropped samples still count as accepted.
  always_ff @(posedge clk) begin
    if (rst) begin
      since_r <= '0;
      first_r <= 1'b1;
    end else begin
      if (rearm_s) begin
        first_r <= 1'b1;
      end else if (accept_s) begin
        first_r <= 1'b0;
      end else begin
        first_r <= first_r;
      end
      if (accept_s) begin
        since_r <= DELTA_WIDTH'(1);
      end else if (since_r != '1) begin
        since_r <= since_r + DELTA_WIDTH'(1);
      end else begin
        since_r <= since_r;
      end
    end
  end

  // Drop counter and the overflow mark carried by the next pushed packet.
  always_ff @(posedge clk) begin
    if (rst) begin
      dropped_count_r <= '0;
      ovf_pend_r      <= 1'b0;
    end else begin
      if (clr_drops_s) begin
        dropped_count_r <= '0;
      end else if (drop_s && (dropped_count_r != '1)) begin
        dropped_count_r <= dropped_count_r + DROP_WIDTH'(1);
      end else begin
        dropped_count_r <= dropped_count_r;
      end
      if (drop_s) begin
        ovf_pend_r <= 1'b1;
      end else if (push_s) begin
        ovf_pend_r <= 1'b0;
      end else begin
        ovf_pend_r <= ovf_pend_r;
      end
    end
  end

  cms_sync_fifo #(
    .WIDTH (PKT_W),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk       (clk),
    .rst       (rst),
    .push      (push_s),
    .push_data (push_data_s),
    .pop       (pop_s),
    .pop_data  (pop_data_s),
    .full      (fifo_full_s),
    .empty     (fifo_empty_s)
  );

  assign pkt.out_valid = !fifo_empty_s;
  assign {pkt.out_pc, pkt.out_instr, pkt.out_delta, pkt.out_ovf, pkt.out_last} = pop_data_s;
  assign dropped_count = dropped_count_r;
  assign gate_state    = state_r;

endmodule

// File: tb/tb_cms_trace_gate.sv
// Directed self-checking bench for cms_trace_gate: trigger window, range
// filtering, back-pressure with drops, WFI termination and mid-stream reset.
module tb_cms_trace_gate;
  import cms_trace_gate_pkg::*;

  localparam int XLEN = 64;
  localparam int IW   = 32;
  localparam int DW   = 32;
  localparam int DRW  = 16;

  logic            clk;
  logic            rst;
  logic [XLEN-1:0] pc;
  logic [IW-1:0]   instr;
  logic            pc_valid;
  logic            en;
  logic [7:0]      ctrl_addr;
  logic [XLEN-1:0] ctrl_wdata;
  logic            ctrl_we;
  logic [DRW-1:0]  dropped_count;
  logic [1:0]      gate_state;

  int n_checks;
  int n_errors;

  logic [63:0] q_pc[$];
  logic [63:0] q_delta[$];
  logic [31:0] q_instr[$];
  logic        q_ovf[$];
  logic        q_last[$];

  cms_trace_gate_if #(.XLEN(XLEN), .INSTR_WIDTH(IW), .DELTA_WIDTH(DW)) gif ();

  cms_trace_gate #(
    .XLEN(XLEN), .INSTR_WIDTH(IW), .NUM_RANGES(4), .NUM_TRIGGERS(2),
    .FIFO_DEPTH(8), .DELTA_WIDTH(DW), .DROP_WIDTH(DRW)
  ) dut (
    .clk           (clk),
    .rst           (rst),
    .pc            (pc),
    .instr         (instr),
    .pc_valid      (pc_valid),
    .en            (en),
    .ctrl_addr     (ctrl_addr),
    .ctrl_wdata    (ctrl_wdata),
    .ctrl_we       (ctrl_we),
    .pkt           (gif),
    .dropped_count (dropped_count),
    .gate_state    (gate_state)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Record every completed transfer, sampled mid-cycle.
  always @(negedge clk) begin
    if (!rst && gif.out_valid && gif.out_ready) begin
      q_pc.push_back(gif.out_pc);
      q_delta.push_back(64'(gif.out_delta));
      q_instr.push_back(gif.out_instr);
      q_ovf.push_back(gif.out_ovf);
      q_last.push_back(gif.out_last);
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog: got timeout, expected finish");
    $fatal(1, "watchdog");
  end

  task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic cyc(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic wr(input logic [7:0] a, input logic [63:0] d);
    ctrl_addr  = a;
    ctrl_wdata = d;
    ctrl_we    = 1'b1;
    cyc(1);
    ctrl_we    = 1'b0;
  endtask

  task automatic smp(input logic [63:0] p, input logic [31:0] i);
    pc       = p;
    instr    = i;
    pc_valid = 1'b1;
    cyc(1);
  endtask

  task automatic clear_q();
    q_pc.delete();
    q_delta.delete();
    q_instr.delete();
    q_ovf.delete();
    q_last.delete();
  endtask

  task automatic do_reset();
    rst      = 1'b1;
    pc_valid = 1'b0;
    ctrl_we  = 1'b0;
    cyc(2);
    rst = 1'b0;
    clear_q();
  endtask

  task automatic drain();
    int k;
    k = 0;
    pc_valid = 1'b0;
    cyc(2);
    while (gif.out_valid && k < 50) begin
      cyc(1);
      k++;
    end
    check_eq("drain_done", 64'(gif.out_valid), 64'd0);
  endtask

  initial begin
    n_checks      = 0;
    n_errors      = 0;
    rst           = 1'b1;
    pc            = '0;
    instr         = '0;
    pc_valid      = 1'b0;
    en            = 1'b1;
    ctrl_addr     = 8'h00;
    ctrl_wdata    = '0;
    ctrl_we       = 1'b0;
    gif.out_ready = 1'b0;
    do_reset();

    // Reset state
    check_eq("rst_valid", 64'(gif.out_valid), 64'd0);
    check_eq("rst_pc", gif.out_pc, 64'd0);
    check_eq("rst_delta", 64'(gif.out_delta), 64'd0);
    check_eq("rst_drops", 64'(dropped_count), 64'd0);
    check_eq("rst_state", 64'(gate_state), 64'd0);

    // 1: free-running trace, latency and deltas
    gif.out_ready = 1'b1;
    smp(64'h100, 32'h0);
    check_eq("s1_lat_valid", 64'(gif.out_valid), 64'd0);
    smp(64'h104, 32'h0);
    check_eq("lat2_valid", 64'(gif.out_valid), 64'd1);
    check_eq("lat2_pc", gif.out_pc, 64'h100);
    smp(64'h108, 32'h0);
    drain();
    check_eq("s1_count", 64'(q_pc.size()), 64'd3);
    check_eq("s1_pc2", q_pc[2], 64'h108);
    check_eq("s1_d0", q_delta[0], 64'd0);
    check_eq("s1_d1", q_delta[1], 64'd1);
    check_eq("s1_d2", q_delta[2], 64'd1);

    // 2: start/end trigger window
    do_reset();
    gif.out_ready = 1'b1;
    wr(8'h30, 64'h200);
    wr(8'h40, 64'h240);
    wr(8'h50, 64'h5);
    for (int k = 0; k < 7; k++) smp(64'h1F0 + 64'(k) * 64'h10, 32'h0);
    drain();
    check_eq("s2_count", 64'(q_pc.size()), 64'd5);
    check_eq("s2_pc0", q_pc[0], 64'h200);
    check_eq("s2_pc4", q_pc[4], 64'h240);
    check_eq("s2_last0", 64'(q_last[0]), 64'd0);
    check_eq("s2_last4", 64'(q_last[4]), 64'd1);
    check_eq("s2_d1", q_delta[1], 64'd1);
    check_eq("s2_halted", 64'(gate_state), 64'd2);
    wr(8'h60, 64'h0);
    check_eq("s2_rearm", 64'(gate_state), 64'd0);

    // 3: include range with an exclude hole
    do_reset();
    gif.out_ready = 1'b1;
    wr(8'h00, 64'h1000);
    wr(8'h10, 64'h1FFF);
    wr(8'h20, 64'h1);
    wr(8'h01, 64'h1800);
    wr(8'h11, 64'h18FF);
    wr(8'h21, 64'h3);
    smp(64'h0FFF, 32'h0);
    smp(64'h1000, 32'h0);
    smp(64'h1800, 32'h0);
    smp(64'h18FF, 32'h0);
    smp(64'h1900, 32'h0);
    smp(64'h1FFF, 32'h0);
    smp(64'h2000, 32'h0);
    drain();
    check_eq("s3_count", 64'(q_pc.size()), 64'd3);
    check_eq("s3_pc0", q_pc[0], 64'h1000);
    check_eq("s3_pc1", q_pc[1], 64'h1900);
    check_eq("s3_pc2", q_pc[2], 64'h1FFF);
    check_eq("s3_d1", q_delta[1], 64'd3);
    check_eq("s3_d2", q_delta[2], 64'd1);

    // 4: back-pressure, drops and overflow mark
    do_reset();
    gif.out_ready = 1'b0;
    for (int k = 0; k < 10; k++) smp(64'h400 + 64'(k) * 64'h4, 32'h0);
    pc_valid = 1'b0;
    cyc(3);
    check_eq("s4_drops", 64'(dropped_count), 64'd2);
    check_eq("s4_hold_valid", 64'(gif.out_valid), 64'd1);
    check_eq("s4_hold_pc", gif.out_pc, 64'h400);
    gif.out_ready = 1'b1;
    drain();
    smp(64'h500, 32'h0);
    drain();
    check_eq("s4_count", 64'(q_pc.size()), 64'd9);
    check_eq("s4_ovf0", 64'(q_ovf[0]), 64'd0);
    check_eq("s4_pc7", q_pc[7], 64'h41C);
    check_eq("s4_pc8", q_pc[8], 64'h500);
    check_eq("s4_ovf8", 64'(q_ovf[8]), 64'd1);
    wr(8'h61, 64'h0);
    check_eq("s4_clear", 64'(dropped_count), 64'd0);

    // 5: WFI ends the window; a later start PC stays gated
    do_reset();
    gif.out_ready = 1'b1;
    wr(8'h30, 64'h200);
    wr(8'h50, 64'h1);
    smp(64'h200, 32'h0);
    smp(64'h204, 32'h0);
    smp(64'h300, WFI_INSTRUCTION);
    smp(64'h200, 32'h0);
    drain();
    check_eq("s5_count", 64'(q_pc.size()), 64'd3);
    check_eq("s5_pc2", q_pc[2], 64'h300);
    check_eq("s5_instr2", 64'(q_instr[2]), 64'h1050_0073);
    check_eq("s5_last2", 64'(q_last[2]), 64'd1);
    check_eq("s5_last1", 64'(q_last[1]), 64'd0);
    check_eq("s5_halted", 64'(gate_state), 64'd2);

    // 6: reset with packets buffered
    do_reset();
    gif.out_ready = 1'b0;
    wr(8'h30, 64'h600);
    wr(8'h50, 64'h1);
    for (int k = 0; k < 5; k++) smp(64'h600 + 64'(k) * 64'h4, 32'h0);
    pc_valid = 1'b0;
    cyc(2);
    check_eq("s6_pre_state", 64'(gate_state), 64'd1);
    check_eq("s6_pre_valid", 64'(gif.out_valid), 64'd1);
    clear_q();
    rst           = 1'b1;
    gif.out_ready = 1'b1;
    cyc(1);
    rst = 1'b0;
    check_eq("s6_valid", 64'(gif.out_valid), 64'd0);
    check_eq("s6_drops", 64'(dropped_count), 64'd0);
    check_eq("s6_state", 64'(gate_state), 64'd0);
    check_eq("s6_pc", gif.out_pc, 64'd0);
    cyc(3);
    check_eq("s6_still_empty", 64'(gif.out_valid), 64'd0);
    check_eq("s6_no_xfer", 64'(q_pc.size()), 64'd0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/cms_trace_gate.md
CMS_TRACE_GATE -- requirements
Module: cms_trace_gate

Interface
REQ-001 The block SHALL have these parameters:
- XLEN, 64, PC width.
- INSTR_WIDTH, 32, instruction width.
- NUM_RANGES, 4, number of address-range filters (1..16).
- NUM_TRIGGERS, 2, number of start/end trigger pairs (1..16).
- FIFO_DEPTH, 8, output buffer entries (power of 2, at least 2).
- DELTA_WIDTH, 32, width of the timestamp delta.
- DROP_WIDTH, 16, width of the dropped-sample counter.
REQ-002 The block SHALL have these ports (name, direction, width, meaning):
- clk, in, 1, the single clock.
- rst, in, 1, synchronous active-high reset.
- pc, in, XLEN, retired PC.
- instr, in, INSTR_WIDTH, retired instruction.
- pc_valid, in, 1, pc/instr valid this cycle.
- en, in, 1, global trace enable.
- ctrl_addr, in, 8, control address: [7:4] function, [3:0] index.
- ctrl_wdata, in, XLEN, control write data.
- ctrl_we, in, 1, level write strobe, one write per cycle.
- out_valid, out, 1, packet valid.
- out_ready, in, 1, sink ready.
- out_pc, out, XLEN, packet PC.
- out_instr, out, INSTR_WIDTH, packet instruction.
- out_delta, out, DELTA_WIDTH, cycles since the previous accepted sample.
- out_ovf, out, 1, at least one sample was dropped before this packet.
- out_last, out, 1, final packet of a trace window.
- dropped_count, out, DROP_WIDTH, saturating count of dropped samples.
- gate_state, out, 2, FSM state.
REQ-003 The one clock and the synchronous active-high reset on clk/rst are already decided and fixed.

Function
REQ-010 The block SHALL register pc, instr and pc_valid once (stage S1); all filter and trigger decisions SHALL use the S1 values.
REQ-011 The FSM SHALL have three states: ARMED=0, TRACING=1, HALTED=2.
REQ-012 In ARMED, an S1-valid PC equal to any enabled start address SHALL move the FSM to TRACING, and that sample SHALL be eligible.
REQ-013 In TRACING, an S1-valid PC equal to any enabled end address, or an S1 instr equal to WFI, SHALL move the FSM to HALTED; that sample SHALL be eligible and carry out_last=1.
REQ-014 HALTED SHALL be left only by a REARM write, which goes to ARMED.
REQ-015 If no start trigger is enabled, ARMED SHALL behave as TRACING (every sample eligible).
REQ-016 If a PC matches both a start and an end address, ARMED SHALL treat it as a start and TRACING SHALL treat it as an end.
REQ-017 A sample SHALL be accepted only when all of the following hold:
- S1 valid and en=1;
- the sample is eligible;
- if any include range is enabled, the PC is inside some enabled include range [lo,hi], bounds inclusive;
- the PC is inside no enabled exclude range.
REQ-018 out_delta SHALL equal the cycle difference between this accepted sample and the previous one, saturating at all-ones; the first sample after reset or REARM SHALL carry delta 0.
REQ-019 An accepted sample SHALL be pushed into the FIFO in the cycle after S1. It SHALL appear on out_valid 2 cycles after it is presented at the inputs when the FIFO is empty.
REQ-020 Handshake rules:
- a packet transfers when out_valid and out_ready are both 1;
- out_valid and the payload SHALL be held stable until the transfer;
- push and pop in the same cycle SHALL be allowed when the FIFO is full.
REQ-021 When an accepted sample meets a full FIFO with no simultaneous pop:
- the sample SHALL be dropped;
- dropped_count SHALL increment, saturating;
- the next pushed packet SHALL carry out_ovf=1.
REQ-022 Control writes SHALL take effect the cycle after ctrl_we. The sample in S1 during the write cycle SHALL use the old values. The control address map is:
- RANGE_LO[i], 0x0i.
- RANGE_HI[i], 0x1i.
- RANGE_CFG[i], 0x2i: bit0 enable, bit1 exclude.
- TRIG_START[j], 0x3j.
- TRIG_END[j], 0x4j.
- TRIG_EN, 0x50: bits[N-1:0] start enables, bits[2N-1:N] end enables.
- REARM, 0x60.
- CLEAR_DROPS, 0x61.
- Out-of-range indices SHALL be ignored.
REQ-023 REARM SHALL force ARMED from any state, reset the delta reference and leave the FIFO contents intact; CLEAR_DROPS SHALL zero dropped_count.

Reset
REQ-030 rst SHALL take effect synchronously and set the following:
- out_valid=0, FIFO empty, all payload outputs 0;
- dropped_count=0, the pending overflow flag clear;
- gate_state=ARMED;
- all ranges and triggers disabled, lo=0, hi=all-ones;
- S1 valid=0.
REQ-031 A reset asserted mid-transfer SHALL discard all buffered packets with no partial output.

Structure
REQ-040 The shared package SHALL hold the FSM state enum, the control function codes and WFI_INSTRUCTION.
REQ-041 The output buffer SHALL be a sub-module, cms_sync_fifo, parametrised by width and depth and exposing full/empty flags.

Verification
REQ-050 The bench SHALL cover these directed scenarios:
- No triggers or ranges enabled, pc 0x100, 0x104, 0x108 on consecutive cycles with out_ready=1 -> three packets, deltas 0, 1, 1, first out_valid 2 cycles after the first input.
- Start 0x200 and end 0x240 enabled, PCs 0x1F0..0x250 step 0x10 -> packets 0x200..0x240 only, out_last=1 on 0x240, gate_state=HALTED; a REARM write -> ARMED.
- Include range [0x1000,0x1FFF] plus exclude range [0x1800,0x18FF], PCs 0x0FFF, 0x1000, 0x1800, 0x18FF, 0x1900, 0x1FFF, 0x2000 -> packets 0x1000, 0x1900, 0x1FFF only.
- FIFO_DEPTH=8, out_ready=0, 10 accepted samples -> 8 buffered, dropped_count=2; then out_ready=1 -> first 8 drained, the next accepted packet has out_ovf=1.
- WFI (0x10500073) at PC 0x300 while TRACING -> packet with out_last=1, then HALTED; a further matching start PC produces no packet.
- rst pulsed for 1 cycle with 5 packets buffered -> next cycle out_valid=0, dropped_count=0, gate_state=ARMED.
